writeback_buffered: RTL and testbench
=====================================

Name: writeback_buffered

Overview:
Parametrised successor to the single-register writeback stage. Accepts completed instructions from the memory stage over a valid/ready handshake. For each one it computes the final register-file value (link address, extended load data, or ALU result) and queues the result in a DEPTH-entry FIFO. It then presents results to the register file and CSR unit with backpressure, and keeps a count of retired instructions.

Parameters:
XLEN, 64, datapath width (32 or 64)
RD_W, 5, destination register index width
PC_INC, 4, link increment added to pc for JAL/JALR
DEPTH, 2, FIFO entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  memory-stage result valid
in_ready  out  1  stage can accept
in_pc  in  XLEN  instruction pc
in_ins  in  32  instruction word
in_alu  in  XLEN  ALU result
in_mem_data  in  XLEN  raw aligned doubleword from memory
in_addr_lo  in  3  low bits of load address
in_csr_data  in  XLEN  CSR write value
in_rd  in  RD_W  destination register
in_reg_w  in  1  register write enable
in_mem_r  in  1  instruction is a load
in_csr_w  in  1  CSR write enable
flush  in  1  discard all queued results
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_reg_w  out  1  head register write enable
out_rd  out  RD_W  head destination
out_data  out  XLEN  head register value
out_csr_w  out  1  head CSR write enable
out_csr_data  out  XLEN  head CSR value
out_pc  out  XLEN  head pc
retire_count  out  32  entries popped since reset

Behaviour:
- Reset: FIFO empty, count=0, out_valid=0, in_ready=1, retire_count=0. All out_* payload fields read 0 while empty.
- Push when in_valid&&in_ready. Pop when out_valid&&out_ready.
- in_ready = (count<DEPTH). It is registered-state based only and must not depend on out_ready. When full, a same-cycle pop does not enable a push.
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle.
- Push and pop may occur in the same cycle when the FIFO is neither empty nor full. Count is unchanged in that case.
- Read/write pointers wrap modulo DEPTH.
- Data select is computed at push time; opcode = in_ins[6:0]:
  - 1101111 (JAL) or 1100111 (JALR): in_pc+PC_INC, truncated to XLEN.
  - else if in_mem_r: shifted = in_mem_data >> (in_addr_lo*8), then extended by funct3 = in_ins[14:12]:
    - 000 sign byte, 001 sign half, 010 sign word, 011 doubleword.
    - 100 zero byte, 101 zero half, 110 zero word.
    - 111 yields 0.
    - For XLEN=32, 011 and 110 behave as 010.
  - else in_alu.
- Stored reg_w = in_reg_w && (in_rd!=0). x0 is never written.
- CSR fields pass through unchanged.
- flush: on the next edge, count=0, pointers=0, out_valid=0. A push or pop in the flush cycle is discarded and retire_count does not increment.
- flush takes priority over push and pop. rst takes priority over flush.
- retire_count increments by 1 per pop and wraps 0xFFFFFFFF -> 0.
- Reset asserted mid-operation empties the FIFO at once. There is no partial retire.

Test Plan:
- Reset, then single push of ALU op (opcode 0110011, in_alu=0x1234, rd=5, reg_w=1) with out_ready=1 -> next cycle out_valid=1, out_data=0x1234, out_rd=5. One cycle later out_valid=0 and retire_count=1.
- JAL at in_pc=0x80000000 -> out_data=0x80000004. JALR with rd=0, reg_w=1 -> out_reg_w=0.
- Load LB, in_mem_data=0x00000000_0000_80FF, addr_lo=1 -> out_data=0xFFFFFFFF_FFFFFF80. Same with LBU -> 0x80. LW at addr_lo=4 on 0x87654321_00000000 -> 0xFFFFFFFF_87654321. LWU -> 0x87654321.
- Hold out_ready=0 and push 3 entries with DEPTH=2 -> in_ready drops after 2 accepted and the 3rd is held. Release out_ready -> entries drain in order, 3rd accepted, retire_count=3.
- Fill the FIFO with 2 entries and assert flush together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, count=0, retire_count unchanged, in_ready=1.
- Force retire_count to 0xFFFFFFFF (e.g. via a bench force/deposit on the counter register), then one pop -> retire_count=0.

Source files
------------

// File: rtl/writeback_buffered_if.sv
// Writeback bus: memory-stage results in, register-file/CSR results out.
// Signal names match the writeback stage port list so both ends read the same.
//   slave  : the writeback stage (consumes in_*, flush, out_ready; drives the rest)
//   master : the surrounding pipeline / bench (drives in_*, flush, out_ready)
interface writeback_buffered_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RD_W = 5
);
  // Memory stage -> writeback
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_ins;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_mem_data;
  logic [2:0]      in_addr_lo;
  logic [XLEN-1:0] in_csr_data;
  logic [RD_W-1:0] in_rd;
  logic            in_reg_w;
  logic            in_mem_r;
  logic            in_csr_w;
  logic            flush;

  // Writeback -> register file / CSR unit
  logic            out_valid;
  logic            out_ready;
  logic            out_reg_w;
  logic [RD_W-1:0] out_rd;
  logic [XLEN-1:0] out_data;
  logic            out_csr_w;
  logic [XLEN-1:0] out_csr_data;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     retire_count;

  modport slave (
    input  in_valid, in_pc, in_ins, in_alu, in_mem_data, in_addr_lo, in_csr_data,
    input  in_rd, in_reg_w, in_mem_r, in_csr_w, flush, out_ready,
    output in_ready, out_valid, out_reg_w, out_rd, out_data, out_csr_w, out_csr_data,
    output out_pc, retire_count
  );

  modport master (
    output in_valid, in_pc, in_ins, in_alu, in_mem_data, in_addr_lo, in_csr_data,
    output in_rd, in_reg_w, in_mem_r, in_csr_w, flush, out_ready,
    input  in_ready, out_valid, out_reg_w, out_rd, out_data, out_csr_w, out_csr_data,
    input  out_pc, retire_count
  );
endinterface

// File: rtl/writeback_buffered.sv
// Buffered writeback stage.
// Accepts completed instructions over a valid/ready handshake, computes the final
// register value (link address, extended load data or ALU result) at push time and
// queues it in a DEPTH-entry FIFO presented to the register file / CSR unit.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - writeback_buffered_if.slave: in_* handshake + payload, flush,
//          out_* handshake + payload, retire_count (pops since reset, wrapping)
module writeback_buffered #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned PC_INC = 4,
  parameter int unsigned DEPTH  = 2
) (
  input logic                  clk,
  input logic                  rst,
  writeback_buffered_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;

  // FIFO state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [31:0]   retire_q, retire_d;

  // FIFO storage (not reset; masked by count when empty)
  logic [XLEN-1:0] data_q     [DEPTH];
  logic [XLEN-1:0] csr_data_q [DEPTH];
  logic [XLEN-1:0] pc_q       [DEPTH];
  logic [RD_W-1:0] rd_q       [DEPTH];
  logic            reg_w_q    [DEPTH];
  logic            csr_w_q    [DEPTH];

  logic empty, full, push, pop;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] shifted;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            wb_reg_w;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // in_ready depends only on registered occupancy, never on out_ready.
  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;

  assign push = bus.in_valid & ~full;
  assign pop  = ~empty & bus.out_ready;

  // Result select, evaluated on the incoming instruction.
  assign opcode   = bus.in_ins[6:0];
  assign funct3   = bus.in_ins[14:12];
  assign shifted  = bus.in_mem_data >> {bus.in_addr_lo, 3'b000};
  assign wb_reg_w = bus.in_reg_w & (bus.in_rd != '0);

  always_comb begin
    wb_data = bus.in_alu;
    if (opcode == OpJal || opcode == OpJalr) begin
      wb_data = bus.in_pc + XLEN'(PC_INC);
    end else if (bus.in_mem_r) begin
      // With XLEN=32, the full-width and zero-word cases both reduce to the
      // sign-word result since there are no upper bits to fill.
      unique case (funct3)
        3'b000:  wb_data = XLEN'($signed(shifted[7:0]));
        3'b001:  wb_data = XLEN'($signed(shifted[15:0]));
        3'b010:  wb_data = XLEN'($signed(shifted[31:0]));
        3'b011:  wb_data = shifted;
        3'b100:  wb_data = XLEN'(shifted[7:0]);
        3'b101:  wb_data = XLEN'(shifted[15:0]);
        3'b110:  wb_data = XLEN'(shifted[31:0]);
        default: wb_data = '0;
      endcase
    end
  end

  // Next-state for pointers and counters; flush outranks push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    retire_d = retire_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        retire_d = retire_q + 32'd1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      retire_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      retire_q <= retire_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && push) begin
      data_q[wr_ptr_q]     <= wb_data;
      csr_data_q[wr_ptr_q] <= bus.in_csr_data;
      pc_q[wr_ptr_q]       <= bus.in_pc;
      rd_q[wr_ptr_q]       <= bus.in_rd;
      reg_w_q[wr_ptr_q]    <= wb_reg_w;
      csr_w_q[wr_ptr_q]    <= bus.in_csr_w;
    end
  end

  // Head payload reads zero while the FIFO is empty.
  assign bus.out_data     = empty ? '0 : data_q[rd_ptr_q];
  assign bus.out_csr_data = empty ? '0 : csr_data_q[rd_ptr_q];
  assign bus.out_pc       = empty ? '0 : pc_q[rd_ptr_q];
  assign bus.out_rd       = empty ? '0 : rd_q[rd_ptr_q];
  assign bus.out_reg_w    = empty ? 1'b0 : reg_w_q[rd_ptr_q];
  assign bus.out_csr_w    = empty ? 1'b0 : csr_w_q[rd_ptr_q];
  assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_writeback_buffered.sv
module tb_writeback_buffered;

  logic clk = 1'b0;
  logic rst = 1'b1;

  writeback_buffered_if #(.XLEN(64), .RD_W(5)) bus ();

  writeback_buffered #(
    .XLEN  (64),
    .RD_W  (5),
    .PC_INC(4),
    .DEPTH (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [63:0] csr;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        regw;
    logic        csrw;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  function automatic logic [63:0] model_data(input logic [63:0] pc, input logic [31:0] ins,
                                             input logic [63:0] alu, input logic [63:0] mem,
                                             input logic [2:0] lo, input logic memr);
    logic [63:0] s;
    if (ins[6:0] == 7'h6F || ins[6:0] == 7'h67) return pc + 64'd4;
    if (!memr) return alu;
    s = mem >> (lo * 8);
    case (ins[14:12])
      3'd0: return {{56{s[7]}}, s[7:0]};
      3'd1: return {{48{s[15]}}, s[15:0]};
      3'd2: return {{32{s[31]}}, s[31:0]};
      3'd3: return s;
      3'd4: return {56'd0, s[7:0]};
      3'd5: return {48'd0, s[15:0]};
      3'd6: return {32'd0, s[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  // Scoreboard: handshakes fire at the coming posedge; inputs are stable from negedge.
  always @(negedge clk) begin
    #2;
    if (rst || bus.flush) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_pop", 64'd1, 64'd0);
        end else begin
          cur = sb.pop_front();
          check("sb_data", bus.out_data, cur.data);
          check("sb_rd", 64'(bus.out_rd), 64'(cur.rd));
          check("sb_reg_w", 64'(bus.out_reg_w), 64'(cur.regw));
          check("sb_pc", bus.out_pc, cur.pc);
          check("sb_csr_w", 64'(bus.out_csr_w), 64'(cur.csrw));
          check("sb_csr_data", bus.out_csr_data, cur.csr);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        cur.data = model_data(bus.in_pc, bus.in_ins, bus.in_alu, bus.in_mem_data,
                              bus.in_addr_lo, bus.in_mem_r);
        cur.csr  = bus.in_csr_data;
        cur.pc   = bus.in_pc;
        cur.rd   = bus.in_rd;
        cur.regw = bus.in_reg_w && (bus.in_rd != 5'd0);
        cur.csrw = bus.in_csr_w;
        sb.push_back(cur);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] alu,
                        input logic [63:0] mem, input logic [2:0] lo, input logic [63:0] csr,
                        input logic [4:0] rd, input logic regw, input logic memr,
                        input logic csrw);
    bus.in_pc       = pc;
    bus.in_ins      = ins;
    bus.in_alu      = alu;
    bus.in_mem_data = mem;
    bus.in_addr_lo  = lo;
    bus.in_csr_data = csr;
    bus.in_rd       = rd;
    bus.in_reg_w    = regw;
    bus.in_mem_r    = memr;
    bus.in_csr_w    = csrw;
  endtask

  // Hold in_valid at the current negedge until accepted; returns on the next negedge.
  task automatic wait_accept();
    logic acc;
    logic done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = bus.in_ready;
      @(negedge clk);
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] alu,
                      input logic [63:0] mem, input logic [2:0] lo, input logic [63:0] csr,
                      input logic [4:0] rd, input logic regw, input logic memr,
                      input logic csrw);
    set_in(pc, ins, alu, mem, lo, csr, rd, regw, memr, csrw);
    wait_accept();
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [63:0] mem,
                      input logic [2:0] lo, input logic [63:0] exp);
    send(64'h200, {17'd0, f3, 5'd10, 7'b0000011}, 64'hDEAD, mem, lo, 64'd0, 5'd10, 1'b1, 1'b1,
         1'b0);
    check(tag, bus.out_data, exp);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (!bus.out_valid) break;
      @(negedge clk);
    end
  endtask

  task automatic rand_in();
    logic [31:0] ins;
    logic        memr;
    ins  = $urandom;
    memr = $urandom_range(0, 1) != 0;
    case ($urandom_range(0, 3))
      0: begin ins[6:0] = 7'h33; memr = 1'b0; end
      1: ins[6:0] = 7'h6F;
      2: ins[6:0] = 7'h67;
      default: begin ins[6:0] = 7'h03; memr = 1'b1; end
    endcase
    set_in({$urandom, $urandom}, ins, {$urandom, $urandom}, {$urandom, $urandom},
           3'($urandom_range(0, 7)), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
           $urandom_range(0, 1) != 0, memr, $urandom_range(0, 1) != 0);
    bus.in_valid = 1'b1;
  endtask

  logic [31:0] rc0;
  logic        fire;

  initial begin
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    set_in('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_retire", 64'(bus.retire_count), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_pc", bus.out_pc, 64'd0);

    // Single ALU op, one-cycle latency, then retire.
    bus.out_ready = 1'b1;
    send(64'h100, 32'h0000_0033, 64'h1234, 64'd0, 3'd0, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    check("alu_out_valid", 64'(bus.out_valid), 64'd1);
    check("alu_out_data", bus.out_data, 64'h1234);
    check("alu_out_rd", 64'(bus.out_rd), 64'd5);
    @(negedge clk);
    check("alu_drained", 64'(bus.out_valid), 64'd0);
    check("alu_retire", 64'(bus.retire_count), 64'd1);

    // Link address and x0 suppression.
    send(64'h8000_0000, 32'h0000_00EF, 64'h55, 64'd0, 3'd0, 64'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    check("jal_data", bus.out_data, 64'h8000_0004);
    @(negedge clk);
    send(64'h1000, 32'h0000_0067, 64'h55, 64'd0, 3'd0, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    check("jalr_x0_reg_w", 64'(bus.out_reg_w), 64'd0);
    check("jalr_data", bus.out_data, 64'h1004);
    @(negedge clk);

    // Load extension.
    load("lb", 3'd0, 64'h0000_0000_0000_80FF, 3'd1, 64'hFFFF_FFFF_FFFF_FF80);
    load("lbu", 3'd4, 64'h0000_0000_0000_80FF, 3'd1, 64'h80);
    load("lw", 3'd2, 64'h8765_4321_0000_0000, 3'd4, 64'hFFFF_FFFF_8765_4321);
    load("lwu", 3'd6, 64'h8765_4321_0000_0000, 3'd4, 64'h8765_4321);
    load("lh", 3'd1, 64'h0000_0000_9ABC_0000, 3'd2, 64'hFFFF_FFFF_FFFF_9ABC);
    load("lhu", 3'd5, 64'h0000_0000_9ABC_0000, 3'd2, 64'h9ABC);
    load("ld", 3'd3, 64'hFEDC_BA98_7654_3210, 3'd0, 64'hFEDC_BA98_7654_3210);
    load("f3_111", 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 64'd0);

    // Backpressure: DEPTH=2 holds the third entry until the head drains.
    bus.out_ready = 1'b0;
    rc0 = bus.retire_count;
    send(64'h10, 32'h33, 64'hA1, 64'd0, 3'd0, 64'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    send(64'h14, 32'h33, 64'hA2, 64'd0, 3'd0, 64'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    set_in(64'h18, 32'h33, 64'hA3, 64'd0, 3'd0, 64'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("held_in_ready", 64'(bus.in_ready), 64'd0);
    check("held_head", bus.out_data, 64'hA1);
    bus.out_ready = 1'b1;
    wait_accept();
    wait_drain();
    check("bp_retire", 64'(bus.retire_count - rc0), 64'd3);
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // Flush with concurrent push and pop.
    bus.out_ready = 1'b0;
    rc0 = bus.retire_count;
    send(64'h20, 32'h33, 64'hB1, 64'd0, 3'd0, 64'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    send(64'h24, 32'h33, 64'hB2, 64'd0, 3'd0, 64'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    check("pre_flush_full", 64'(bus.in_ready), 64'd0);
    set_in(64'h28, 32'h33, 64'hB3, 64'd0, 3'd0, 64'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_retire", 64'(bus.retire_count), 64'(rc0));
    check("flush_out_data", bus.out_data, 64'd0);
    @(negedge clk);
    check("flush_no_push", 64'(bus.out_valid), 64'd0);

    // Retire counter wrap.
    bus.out_ready = 1'b0;
    send(64'h30, 32'h33, 64'hC1, 64'd0, 3'd0, 64'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    check("wrap_preset", 64'(bus.retire_count), 64'hFFFF_FFFF);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("wrap_retire", 64'(bus.retire_count), 64'd0);

    // Randomised traffic with random backpressure and occasional flush.
    fire = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.flush     = $urandom_range(0, 59) == 0;
      if (!bus.in_valid || fire) begin
        if ($urandom_range(0, 2) != 0) rand_in();
        else bus.in_valid = 1'b0;
      end
      #1;
      fire = bus.in_valid && bus.in_ready && !bus.flush;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of operation.
    bus.out_ready = 1'b0;
    send(64'h40, 32'h33, 64'hD1, 64'd0, 3'd0, 64'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    send(64'h44, 32'h33, 64'hD2, 64'd0, 3'd0, 64'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_retire", 64'(bus.retire_count), 64'd0);
    check("midrst_out_data", bus.out_data, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
